// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: default geometry, byte width,
// the longest accepted program and the loader state encoding.
package prog_loader_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 1 << DEF_ADDR_W;

  localparam int BYTE_W  = 8;
  localparam int LEN_MAX = DEF_DEPTH;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    HI    = 3'd2,
    LO    = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5,
    CHK   = 3'd6
  } state_t;

  // States in which a new load may be started.
  function automatic logic can_start(state_t s);
    return (s == IDLE) || (s == DONE);
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
//
// Handshake: a byte moves on a rising clk edge where byte_valid && byte_ready.
// byte_ready is registered and depends on loader state only, never on
// byte_valid; the source may hold byte_valid high or drop it at any time, and
// byte_in must be stable whenever byte_valid is high. wr_en is a one-cycle
// strobe per word; wr_addr/wr_data hold their last values when wr_en is low,
// so the memory must qualify writes with wr_en.
interface prog_loader_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
);

  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  // Byte source and memory side.
  modport master (
    output byte_in,
    output byte_valid,
    input  byte_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );

  // The loader itself.
  modport slave (
    input  byte_in,
    input  byte_valid,
    output byte_ready,
    output wr_en,
    output wr_addr,
    output wr_data
  );

endinterface

// File: rtl/prog_loader_byte_pair_asm.sv
// Byte pair assembler: latches the high byte of a word and presents the full
// word as {latched high byte, current byte} so the low byte can be written in
// the same edge it is accepted.
module byte_pair_asm
  import prog_loader_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                hi_load,
  input  logic [BYTE_W-1:0]   byte_in,
  output logic [2*BYTE_W-1:0] word
);

  logic [BYTE_W-1:0] hi_q;

  // High-byte latch, cleared on reset and at the start of every load.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      hi_q <= '0;
    end else if (hi_load) begin
      hi_q <= byte_in;
    end
  end

  assign word = {hi_q, byte_in};

endmodule

// File: rtl/prog_loader.sv
// Program loader: fills instruction memory from a byte stream.
// Stream format: length byte N (1..DEPTH), then N words high byte first.
// Words go to addresses 0..N-1; cpu_hold stays high until the image is in.
// Build option: define PROG_LOADER_CHECKSUM_EN to require a trailing XOR
// checksum byte covering the length byte and all data bytes.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  prog_loader_if.slave bus,
  output logic         cpu_hold,
  output logic         busy,
  output logic         done,
  output logic         err,
  output state_t       dbg_state
);

  // One extra bit so a count of DEPTH words is representable.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [BYTE_W-1:0] LEN_TOP = BYTE_W'(DEPTH);

  state_t            state_q;
  logic [CNT_W-1:0]  len_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              byte_ready_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [DATA_W-1:0] word;
  logic              xfer;
  logic              load_go;
  logic              len_ok;
  logic              last_word;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum_q;
`endif

  assign xfer      = bus.byte_valid && byte_ready_q;
  assign load_go   = start && can_start(state_q);
  assign len_ok    = (bus.byte_in != '0) && (bus.byte_in <= LEN_TOP);
  assign last_word = ((cnt_q + CNT_W'(1)) == len_q);

  byte_pair_asm u_asm (
    .clk     (clk),
    .reset   (reset),
    .clear   (load_go),
    .hi_load (xfer && (state_q == HI)),
    .byte_in (bus.byte_in),
    .word    (word)
  );

  // Loader FSM with all outputs registered; wr_en defaults low so it pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      len_q        <= '0;
      cnt_q        <= '0;
      byte_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      cpu_hold     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q      <= LEN;
            len_q        <= '0;
            cnt_q        <= '0;
            byte_ready_q <= 1'b1;
            cpu_hold     <= 1'b1;
            busy         <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
          end
        end

        LEN: begin
          if (xfer) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q <= csum_q ^ bus.byte_in;
`endif
            if (len_ok) begin
              len_q   <= CNT_W'(bus.byte_in);
              state_q <= HI;
            end else begin
              // Bad length: report and finish without touching memory.
              state_q      <= DONE;
              byte_ready_q <= 1'b0;
              cpu_hold     <= 1'b0;
              busy         <= 1'b0;
              done         <= 1'b1;
              err          <= 1'b1;
            end
          end
        end

        HI: begin
          if (xfer) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q <= csum_q ^ bus.byte_in;
`endif
            state_q <= LO;
          end
        end

        LO: begin
          if (xfer) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q <= csum_q ^ bus.byte_in;
`endif
            state_q      <= WRITE;
            byte_ready_q <= 1'b0;
            wr_en_q      <= 1'b1;
            wr_addr_q    <= cnt_q[ADDR_W-1:0];
            wr_data_q    <= word;
          end
        end

        WRITE: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_word) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state_q      <= CHK;
            byte_ready_q <= 1'b1;
`else
            state_q      <= DONE;
            byte_ready_q <= 1'b0;
            cpu_hold     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b1;
`endif
          end else begin
            state_q      <= HI;
            byte_ready_q <= 1'b1;
          end
        end

`ifdef PROG_LOADER_CHECKSUM_EN
        CHK: begin
          if (xfer) begin
            if (bus.byte_in != csum_q) begin
              err <= 1'b1;
            end
            state_q      <= DONE;
            byte_ready_q <= 1'b0;
            cpu_hold     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b1;
          end
        end
`endif

        default: begin
          state_q      <= IDLE;
          byte_ready_q <= 1'b0;
          cpu_hold     <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

  assign bus.byte_ready = byte_ready_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign dbg_state      = state_q;

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the instruction-memory interface. The processor's address counter and instruction register only read that memory; this block fills it.
- Accepts a byte stream over a valid/ready handshake and assembles 16-bit instruction words, high byte first.
- Writes the words to consecutive instruction-memory addresses starting at 0.
- Holds the processor (cpu_hold) until the program image is fully loaded.

Parameters:
- ADDR_W, 5, instruction-memory address width.
- DATA_W, 16, instruction word width; must be 16 (two bytes per word).
- DEPTH, 32, number of memory words; equals 2**ADDR_W.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE or DONE.
- byte_in  in  8  stream data.
- byte_valid  in  1  byte_in holds a valid byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- wr_en  out  1  instruction-memory write strobe, one cycle per word.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  DATA_W  write data.
- cpu_hold  out  1  high while a load is in progress; drives the processor reset/run gating.
- busy  out  1  FSM is not in IDLE or DONE.
- done  out  1  level; high in DONE until the next start or reset.
- err  out  1  level; bad length (or checksum failure, see Optional Feature); cleared on start or reset.

Behaviour:
- Handshake: a byte transfers on a rising edge where byte_valid && byte_ready. byte_ready is a registered output of state only and does not depend on byte_valid.
- Reset (synchronous): FSM goes to IDLE.
  - All outputs 0: byte_ready, wr_en, wr_addr, wr_data, cpu_hold, busy, done, err.
  - Word counter and byte latch cleared.
  - A reset mid-load abandons the load. Words already written stay in memory.
- States:
  - IDLE: byte_ready=0. On start go to LEN, and assert cpu_hold and busy.
  - LEN: byte_ready=1. The accepted byte is N, the word count.
    - N in 1..DEPTH: store N, go to HI.
    - N=0 or N>DEPTH: set err, go to DONE with no writes.
  - HI: byte_ready=1. Accepted byte is latched as bits 15:8. Go to LO.
  - LO: byte_ready=1. Accepted byte forms bits 7:0. Go to WRITE.
  - WRITE: byte_ready=0. wr_en=1 for exactly this cycle; wr_data = {hi, lo}; wr_addr = word index.
    - Word index then increments.
    - If index+1 == N, go to DONE (or CHK when the optional feature is compiled in); otherwise go to HI.
  - DONE: cpu_hold=0, busy=0, done=1. start re-enters LEN and clears done and err.
- Timing:
  - Latency from acceptance of a word's low byte to wr_en is 1 cycle.
  - Peak throughput is 1 word per 3 cycles.
  - No bytes are lost across bubbles: the FSM waits indefinitely in HI, LO and LEN.
- wr_addr and wr_data hold their last values outside WRITE. The memory must qualify writes with wr_en.
- Boundaries:
  - Word index N-1 = 31 is written at address 31 and never wraps.
  - start while busy is ignored.
  - start and reset in the same cycle: reset wins.
  - byte_valid in IDLE or DONE is not accepted.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit running XOR covers the length byte and all data bytes; it is cleared on entry to LEN.
  - After the last WRITE, the FSM enters CHK (byte_ready=1) and accepts one byte.
  - If that byte differs from the running XOR, set err. In both cases go to DONE.
- Undefined: no CHK state, no XOR register; WRITE goes straight to DONE after the last word.

Decomposition:
- Shared package prog_loader_pkg holds:
  - the state enum (IDLE, LEN, HI, LO, WRITE, DONE, CHK);
  - the BYTE_W=8 constant;
  - the LEN_MAX=DEPTH constant.
- The FSM and datapath stay in one module; no sub-module is required.
- An optional sub-module byte_pair_asm (hi/lo latch plus word assembly) may be split out for reuse.

Test Plan:
- Reset, then start, then stream 02 12 34 AB CD with byte_valid held high.
  - Expect wr_en pulses with (addr 0, 0x1234) then (addr 1, 0xABCD).
  - Expect done=1, cpu_hold=0, err=0.
- Length byte 00, then separately length 0x21.
  - Each case: err=1, done=1, no wr_en pulses.
- Length 0x20 followed by 64 bytes.
  - Expect 32 writes at addresses 0..31, last word at addr 31, no wrap.
- Stream 01 12 34 with byte_valid toggling 1-0-0-1-0-1.
  - Expect exactly one write of 0x1234 at addr 0.
  - Expect byte_ready low during WRITE.
- Assert reset in the cycle after the first data byte of a 3-word load.
  - Expect all outputs 0 next cycle.
  - A fresh start then loads correctly from addr 0.
- With PROG_LOADER_CHECKSUM_EN: stream 01 12 34 27 (01^12^34 = 27).
  - Expect err=0.
  - Repeat with checksum byte 28: expect err=1 and done=1.
